axi_bus: RTL and testbench

- Single-clock AXI4 register slice sitting between an AXI manager (slave port `s_`) and an AXI subordinate (master port `m_`). It carries the full AXI_BUS channel set used by the SoC.
- Every one of the five channels (AW, W, B, AR, R) is decoupled by a 2-entry skid buffer. All valid/ready/payload outputs are therefore registered, for timing closure ahead of memory or CDC logic.
- Throughput: 1 beat/cycle per channel. Latency: 1 cycle.

---
 rtl/axi_bus_pkg.sv | 60 ++++++
 rtl/axi_bus_if.sv | 85 ++++++++
 rtl/axi_bus_skid.sv | 67 ++++++
 rtl/axi_bus.sv | 97 +++++++++
 tb/tb_axi_bus.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_bus_pkg.sv
// rtl/axi_bus_pkg.sv - widths and per-channel payload structs for the AXI register slice
package axi_bus_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_ID_WIDTH   = 6;
    localparam int AXI_USER_WIDTH = 1;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [5:0]                atop;
        logic [AXI_USER_WIDTH-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [1:0]                resp;
        logic [AXI_USER_WIDTH-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic                      lock;
        logic [3:0]                cache;
        logic [2:0]                prot;
        logic [3:0]                qos;
        logic [3:0]                region;
        logic [AXI_USER_WIDTH-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]   id;
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic [AXI_USER_WIDTH-1:0] user;
    } r_chan_t;

endpackage

// File: rtl/axi_bus_if.sv
// rtl/axi_bus_if.sv - full five-channel AXI bus with manager/subordinate modports
interface axi_bus_if;
    import axi_bus_pkg::*;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_bus_skid.sv
// rtl/axi_bus_skid.sv - generic 2-entry skid buffer with fully registered outputs
module axi_bus_skid #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] spare;
    logic             push;
    logic             pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Occupancy and handshake flags; ready/valid come straight from flops.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count     <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            count     <= count_next;
            in_ready  <= (count_next < 2'd2);
            out_valid <= (count_next != 2'd0);
        end
    end

    // Head register drives the output; spare holds the second beat while stalled.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_data <= '0;
            spare    <= '0;
        end else if (pop) begin
            if (count == 2'd2) begin
                out_data <= spare;
            end else if (push) begin
                out_data <= in_data;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                out_data <= in_data;
            end else begin
                spare <= in_data;
            end
        end
    end

endmodule

// File: rtl/axi_bus.sv
// rtl/axi_bus.sv - AXI4 register slice: one skid buffer per channel
module axi_bus
    import axi_bus_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    axi_bus_if.slave  s,
    axi_bus_if.master m
);

    aw_chan_t aw_in, aw_out;
    w_chan_t  w_in,  w_out;
    b_chan_t  b_in,  b_out;
    ar_chan_t ar_in, ar_out;
    r_chan_t  r_in,  r_out;

    assign aw_in = '{id: s.aw_id, addr: s.aw_addr, len: s.aw_len, size: s.aw_size,
                     burst: s.aw_burst, lock: s.aw_lock, cache: s.aw_cache, prot: s.aw_prot,
                     qos: s.aw_qos, region: s.aw_region, atop: s.aw_atop, user: s.aw_user};
    assign w_in  = '{data: s.w_data, strb: s.w_strb, last: s.w_last, user: s.w_user};
    assign b_in  = '{id: m.b_id, resp: m.b_resp, user: m.b_user};
    assign ar_in = '{id: s.ar_id, addr: s.ar_addr, len: s.ar_len, size: s.ar_size,
                     burst: s.ar_burst, lock: s.ar_lock, cache: s.ar_cache, prot: s.ar_prot,
                     qos: s.ar_qos, region: s.ar_region, user: s.ar_user};
    assign r_in  = '{id: m.r_id, data: m.r_data, resp: m.r_resp, last: m.r_last, user: m.r_user};

    assign m.aw_id     = aw_out.id;
    assign m.aw_addr   = aw_out.addr;
    assign m.aw_len    = aw_out.len;
    assign m.aw_size   = aw_out.size;
    assign m.aw_burst  = aw_out.burst;
    assign m.aw_lock   = aw_out.lock;
    assign m.aw_cache  = aw_out.cache;
    assign m.aw_prot   = aw_out.prot;
    assign m.aw_qos    = aw_out.qos;
    assign m.aw_region = aw_out.region;
    assign m.aw_atop   = aw_out.atop;
    assign m.aw_user   = aw_out.user;

    assign m.w_data = w_out.data;
    assign m.w_strb = w_out.strb;
    assign m.w_last = w_out.last;
    assign m.w_user = w_out.user;

    assign s.b_id   = b_out.id;
    assign s.b_resp = b_out.resp;
    assign s.b_user = b_out.user;

    assign m.ar_id     = ar_out.id;
    assign m.ar_addr   = ar_out.addr;
    assign m.ar_len    = ar_out.len;
    assign m.ar_size   = ar_out.size;
    assign m.ar_burst  = ar_out.burst;
    assign m.ar_lock   = ar_out.lock;
    assign m.ar_cache  = ar_out.cache;
    assign m.ar_prot   = ar_out.prot;
    assign m.ar_qos    = ar_out.qos;
    assign m.ar_region = ar_out.region;
    assign m.ar_user   = ar_out.user;

    assign s.r_id   = r_out.id;
    assign s.r_data = r_out.data;
    assign s.r_resp = r_out.resp;
    assign s.r_last = r_out.last;
    assign s.r_user = r_out.user;

    axi_bus_skid #(.WIDTH($bits(aw_chan_t))) u_aw (
        .clk(clk), .rstn(rstn),
        .in_data(aw_in), .in_valid(s.aw_valid), .in_ready(s.aw_ready),
        .out_data(aw_out), .out_valid(m.aw_valid), .out_ready(m.aw_ready)
    );

    axi_bus_skid #(.WIDTH($bits(w_chan_t))) u_w (
        .clk(clk), .rstn(rstn),
        .in_data(w_in), .in_valid(s.w_valid), .in_ready(s.w_ready),
        .out_data(w_out), .out_valid(m.w_valid), .out_ready(m.w_ready)
    );

    axi_bus_skid #(.WIDTH($bits(b_chan_t))) u_b (
        .clk(clk), .rstn(rstn),
        .in_data(b_in), .in_valid(m.b_valid), .in_ready(m.b_ready),
        .out_data(b_out), .out_valid(s.b_valid), .out_ready(s.b_ready)
    );

    axi_bus_skid #(.WIDTH($bits(ar_chan_t))) u_ar (
        .clk(clk), .rstn(rstn),
        .in_data(ar_in), .in_valid(s.ar_valid), .in_ready(s.ar_ready),
        .out_data(ar_out), .out_valid(m.ar_valid), .out_ready(m.ar_ready)
    );

    axi_bus_skid #(.WIDTH($bits(r_chan_t))) u_r (
        .clk(clk), .rstn(rstn),
        .in_data(r_in), .in_valid(m.r_valid), .in_ready(m.r_ready),
        .out_data(r_out), .out_valid(s.r_valid), .out_ready(s.r_ready)
    );

endmodule

// File: tb/tb_axi_bus.sv
// tb/tb_axi_bus.sv - self-checking bench for the axi_bus register slice
module tb_axi_bus;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    axi_bus_if s_bus ();
    axi_bus_if m_bus ();

    axi_bus dut (.clk(clk), .rstn(rstn), .s(s_bus), .m(m_bus));

    // channel index: 0 aw, 1 w, 2 b, 3 ar, 4 r
    logic [127:0] in_pl [5];
    logic [127:0] out_pl [5];
    logic         in_v [5];
    logic         in_r [5];
    logic         out_v [5];
    logic         out_r [5];

    assign in_pl[0]  = 128'({s_bus.aw_id, s_bus.aw_addr, s_bus.aw_len, s_bus.aw_size, s_bus.aw_burst,
                             s_bus.aw_lock, s_bus.aw_cache, s_bus.aw_prot, s_bus.aw_qos,
                             s_bus.aw_region, s_bus.aw_atop, s_bus.aw_user});
    assign out_pl[0] = 128'({m_bus.aw_id, m_bus.aw_addr, m_bus.aw_len, m_bus.aw_size, m_bus.aw_burst,
                             m_bus.aw_lock, m_bus.aw_cache, m_bus.aw_prot, m_bus.aw_qos,
                             m_bus.aw_region, m_bus.aw_atop, m_bus.aw_user});
    assign in_pl[1]  = 128'({s_bus.w_data, s_bus.w_strb, s_bus.w_last, s_bus.w_user});
    assign out_pl[1] = 128'({m_bus.w_data, m_bus.w_strb, m_bus.w_last, m_bus.w_user});
    assign in_pl[2]  = 128'({m_bus.b_id, m_bus.b_resp, m_bus.b_user});
    assign out_pl[2] = 128'({s_bus.b_id, s_bus.b_resp, s_bus.b_user});
    assign in_pl[3]  = 128'({s_bus.ar_id, s_bus.ar_addr, s_bus.ar_len, s_bus.ar_size, s_bus.ar_burst,
                             s_bus.ar_lock, s_bus.ar_cache, s_bus.ar_prot, s_bus.ar_qos,
                             s_bus.ar_region, s_bus.ar_user});
    assign out_pl[3] = 128'({m_bus.ar_id, m_bus.ar_addr, m_bus.ar_len, m_bus.ar_size, m_bus.ar_burst,
                             m_bus.ar_lock, m_bus.ar_cache, m_bus.ar_prot, m_bus.ar_qos,
                             m_bus.ar_region, m_bus.ar_user});
    assign in_pl[4]  = 128'({m_bus.r_id, m_bus.r_data, m_bus.r_resp, m_bus.r_last, m_bus.r_user});
    assign out_pl[4] = 128'({s_bus.r_id, s_bus.r_data, s_bus.r_resp, s_bus.r_last, s_bus.r_user});

    assign in_v[0] = s_bus.aw_valid;  assign in_r[0] = s_bus.aw_ready;
    assign out_v[0] = m_bus.aw_valid; assign out_r[0] = m_bus.aw_ready;
    assign in_v[1] = s_bus.w_valid;   assign in_r[1] = s_bus.w_ready;
    assign out_v[1] = m_bus.w_valid;  assign out_r[1] = m_bus.w_ready;
    assign in_v[2] = m_bus.b_valid;   assign in_r[2] = m_bus.b_ready;
    assign out_v[2] = s_bus.b_valid;  assign out_r[2] = s_bus.b_ready;
    assign in_v[3] = s_bus.ar_valid;  assign in_r[3] = s_bus.ar_ready;
    assign out_v[3] = m_bus.ar_valid; assign out_r[3] = m_bus.ar_ready;
    assign in_v[4] = m_bus.r_valid;   assign in_r[4] = m_bus.r_ready;
    assign out_v[4] = s_bus.r_valid;  assign out_r[4] = s_bus.r_ready;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference: each channel is a two-deep FIFO of beats; ready is withheld during reset
    // and for the first edge after it.
    initial begin
        logic [127:0] fifo [5][2];
        int           cnt [5];
        bit           live;
        bit           do_push, do_pop;
        string        cn [5];
        cn = '{"aw", "w", "b", "ar", "r"};
        live = 1'b0;
        for (int c = 0; c < 5; c++) cnt[c] = 0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                for (int c = 0; c < 5; c++) cnt[c] = 0;
                live = 1'b0;
            end else begin
                for (int c = 0; c < 5; c++) begin
                    do_push = in_v[c] && live && (cnt[c] < 2);
                    do_pop  = out_r[c] && (cnt[c] > 0);
                    if (do_pop) begin
                        fifo[c][0] = fifo[c][1];
                        cnt[c]--;
                    end
                    if (do_push) begin
                        fifo[c][cnt[c]] = in_pl[c];
                        cnt[c]++;
                    end
                end
                live = 1'b1;
            end
            #2;
            for (int c = 0; c < 5; c++) begin
                chk({cn[c], "_in_ready"}, in_r[c], live && (cnt[c] < 2));
                chk({cn[c], "_out_valid"}, out_v[c], cnt[c] > 0);
                if (cnt[c] > 0) chk({cn[c], "_payload"}, out_pl[c], fifo[c][0]);
            end
        end
    end

    task automatic clear_inputs();
        s_bus.aw_id = '0; s_bus.aw_addr = '0; s_bus.aw_len = '0; s_bus.aw_size = '0;
        s_bus.aw_burst = '0; s_bus.aw_lock = '0; s_bus.aw_cache = '0; s_bus.aw_prot = '0;
        s_bus.aw_qos = '0; s_bus.aw_region = '0; s_bus.aw_atop = '0; s_bus.aw_user = '0;
        s_bus.aw_valid = 1'b0;
        s_bus.w_data = '0; s_bus.w_strb = '0; s_bus.w_last = 1'b0; s_bus.w_user = '0;
        s_bus.w_valid = 1'b0;
        s_bus.b_ready = 1'b0;
        s_bus.ar_id = '0; s_bus.ar_addr = '0; s_bus.ar_len = '0; s_bus.ar_size = '0;
        s_bus.ar_burst = '0; s_bus.ar_lock = '0; s_bus.ar_cache = '0; s_bus.ar_prot = '0;
        s_bus.ar_qos = '0; s_bus.ar_region = '0; s_bus.ar_user = '0; s_bus.ar_valid = 1'b0;
        s_bus.r_ready = 1'b0;
        m_bus.aw_ready = 1'b0; m_bus.w_ready = 1'b0; m_bus.ar_ready = 1'b0;
        m_bus.b_id = '0; m_bus.b_resp = '0; m_bus.b_user = '0; m_bus.b_valid = 1'b0;
        m_bus.r_id = '0; m_bus.r_data = '0; m_bus.r_resp = '0; m_bus.r_last = 1'b0;
        m_bus.r_user = '0; m_bus.r_valid = 1'b0;
    endtask

    task automatic rand_inputs();
        s_bus.aw_id = 6'($urandom); s_bus.aw_addr = $urandom; s_bus.aw_len = 8'($urandom);
        s_bus.aw_size = 3'($urandom); s_bus.aw_burst = 2'($urandom); s_bus.aw_lock = 1'($urandom);
        s_bus.aw_cache = 4'($urandom); s_bus.aw_prot = 3'($urandom); s_bus.aw_qos = 4'($urandom);
        s_bus.aw_region = 4'($urandom); s_bus.aw_atop = 6'($urandom); s_bus.aw_user = 1'($urandom);
        s_bus.aw_valid = 1'($urandom);
        s_bus.w_data = {$urandom, $urandom}; s_bus.w_strb = 8'($urandom);
        s_bus.w_last = 1'($urandom); s_bus.w_user = 1'($urandom); s_bus.w_valid = 1'($urandom);
        s_bus.b_ready = 1'($urandom);
        s_bus.ar_id = 6'($urandom); s_bus.ar_addr = $urandom; s_bus.ar_len = 8'($urandom);
        s_bus.ar_size = 3'($urandom); s_bus.ar_burst = 2'($urandom); s_bus.ar_lock = 1'($urandom);
        s_bus.ar_cache = 4'($urandom); s_bus.ar_prot = 3'($urandom); s_bus.ar_qos = 4'($urandom);
        s_bus.ar_region = 4'($urandom); s_bus.ar_user = 1'($urandom); s_bus.ar_valid = 1'($urandom);
        s_bus.r_ready = 1'($urandom);
        m_bus.aw_ready = 1'($urandom); m_bus.w_ready = 1'($urandom); m_bus.ar_ready = 1'($urandom);
        m_bus.b_id = 6'($urandom); m_bus.b_resp = 2'($urandom); m_bus.b_user = 1'($urandom);
        m_bus.b_valid = 1'($urandom);
        m_bus.r_id = 6'($urandom); m_bus.r_data = {$urandom, $urandom}; m_bus.r_resp = 2'($urandom);
        m_bus.r_last = 1'($urandom); m_bus.r_user = 1'($urandom); m_bus.r_valid = 1'($urandom);
    endtask

    initial begin
        clear_inputs();
        rstn = 1'b0;

        // reset held three cycles while a manager offers AW
        s_bus.aw_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", s_bus.aw_ready, 1'b0);
        chk("rst_w_ready", s_bus.w_ready, 1'b0);
        chk("rst_m_b_ready", m_bus.b_ready, 1'b0);
        chk("rst_m_aw_valid", m_bus.aw_valid, 1'b0);
        chk("rst_s_r_valid", s_bus.r_valid, 1'b0);
        s_bus.aw_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_aw_ready", s_bus.aw_ready, 1'b1);
        chk("post_rst_m_r_ready", m_bus.r_ready, 1'b1);
        chk("post_rst_aw_addr_zero", m_bus.aw_addr, 32'h0);

        // single AW beat held under backpressure
        s_bus.aw_addr = 32'h8000_0040; s_bus.aw_id = 6'd5; s_bus.aw_len = 8'd3;
        s_bus.aw_valid = 1'b1;
        @(negedge clk);
        s_bus.aw_valid = 1'b0;
        chk("aw_valid_1cyc", m_bus.aw_valid, 1'b1);
        chk("aw_addr", m_bus.aw_addr, 32'h8000_0040);
        chk("aw_id", m_bus.aw_id, 6'd5);
        chk("aw_len", m_bus.aw_len, 8'd3);
        @(negedge clk);
        chk("aw_valid_held", m_bus.aw_valid, 1'b1);
        chk("aw_addr_held", m_bus.aw_addr, 32'h8000_0040);
        m_bus.aw_ready = 1'b1;
        @(negedge clk);
        chk("aw_valid_drained", m_bus.aw_valid, 1'b0);
        m_bus.aw_ready = 1'b0;

        // eight-beat W stream with no backpressure
        m_bus.w_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_bus.w_data = 64'(i); s_bus.w_strb = 8'hFF; s_bus.w_last = (i == 7);
            s_bus.w_valid = 1'b1;
            @(negedge clk);
            chk("w_stream_valid", m_bus.w_valid, 1'b1);
            chk("w_stream_data", m_bus.w_data, 64'(i));
            chk("w_stream_last", m_bus.w_last, (i == 7));
            chk("w_stream_ready", s_bus.w_ready, 1'b1);
        end
        s_bus.w_valid = 1'b0; s_bus.w_last = 1'b0;
        @(negedge clk);
        chk("w_stream_end", m_bus.w_valid, 1'b0);
        m_bus.w_ready = 1'b0;

        // R backpressure: A, B accepted, C refused, then drained in order
        s_bus.r_ready = 1'b0;
        m_bus.r_valid = 1'b1; m_bus.r_data = 64'hA;
        @(negedge clk);
        m_bus.r_data = 64'hB;
        @(negedge clk);
        chk("r_full_ready", m_bus.r_ready, 1'b0);
        m_bus.r_data = 64'hC;
        @(negedge clk);
        chk("r_full_ready_hold", m_bus.r_ready, 1'b0);
        chk("r_head_a", s_bus.r_data, 64'hA);
        m_bus.r_valid = 1'b0;
        s_bus.r_ready = 1'b1;
        @(negedge clk);
        chk("r_head_b", s_bus.r_data, 64'hB);
        chk("r_ready_back", m_bus.r_ready, 1'b1);
        @(negedge clk);
        chk("r_no_c", s_bus.r_valid, 1'b0);
        s_bus.r_ready = 1'b0;

        // AR simultaneous push and pop at one entry
        s_bus.ar_addr = 32'd100; s_bus.ar_valid = 1'b1;
        @(negedge clk);
        m_bus.ar_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            s_bus.ar_addr = 32'(100 + i);
            @(negedge clk);
            chk("ar_pp_addr", m_bus.ar_addr, 32'(100 + i));
            chk("ar_pp_ready", s_bus.ar_ready, 1'b1);
        end
        s_bus.ar_valid = 1'b0;
        @(negedge clk);
        chk("ar_pp_drained", m_bus.ar_valid, 1'b0);
        m_bus.ar_ready = 1'b0;

        // reset with two B beats buffered
        s_bus.b_ready = 1'b0;
        m_bus.b_valid = 1'b1; m_bus.b_id = 6'd1;
        @(negedge clk);
        m_bus.b_id = 6'd2;
        @(negedge clk);
        m_bus.b_valid = 1'b0;
        chk("b_buffered", s_bus.b_valid, 1'b1);
        rstn = 1'b0;
        @(negedge clk);
        chk("b_rst_valid", s_bus.b_valid, 1'b0);
        chk("b_rst_id_zero", s_bus.b_id, 6'd0);
        rstn = 1'b1;
        s_bus.b_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("b_discarded", s_bus.b_valid, 1'b0);
        end

        // randomized traffic on all channels with occasional resets
        repeat (1500) begin
            @(negedge clk);
            rand_inputs();
            rstn = ($urandom_range(0, 199) != 0);
        end
        @(negedge clk);
        clear_inputs();
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
